spi_slave_tx: RTL
=================

SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; all logic runs on clk, and reset_n is asynchronous and active-low.
REQ-002 SHALL have parameter CMD_READ, default 8'h03, the opcode that streams JPEG bytes.
REQ-003 SHALL have parameter CMD_STATUS, default 8'h05, the opcode that returns the status byte.
REQ-004 SHALL have port clk, input, 1 bit: system clock, at least 8x spi_sclk.
REQ-005 SHALL have port reset_n, input, 1 bit: async active-low reset.
REQ-006 SHALL have port spi_sclk, input, 1 bit: SPI clock from the ESP32 master, mode 0, asynchronous to clk.
REQ-007 SHALL have port spi_cs_n, input, 1 bit: chip select, active low, asynchronous.
REQ-008 SHALL have port spi_mosi, input, 1 bit: master data, MSB first.
REQ-009 SHALL have port spi_miso, output, 1 bit: slave data, MSB first.
REQ-010 SHALL have port spi_miso_oe, output, 1 bit: MISO pad output enable, high while selected.
REQ-011 SHALL have port frame_ready, input, 1 bit: a JPEG frame is available (je_done level).
REQ-012 SHALL have port spi_data, input, 8 bits: current byte from the upstream JPEG-to-SPI stage.
REQ-013 SHALL have port spi_rd, output, 1 bit: one-clk pulse meaning the current spi_data byte is consumed.

Function
REQ-014 SHALL pass spi_sclk, spi_cs_n and spi_mosi through 2-flop synchronizers, plus a third flop on sclk and cs_n for edge detection; edge latency is at most 3 clk.
REQ-015 SHALL implement states IDLE, CMD, READ, STATUS, DISCARD.
REQ-016 SHALL enter CMD from IDLE on a synchronized cs_n falling edge, clear the bit counter and load the TX shift register with 8'h00.
REQ-017 SHALL sample synchronized mosi into the RX shift register on each synchronized sclk rising edge, and increment the 3-bit bit counter on that edge.
REQ-018 SHALL shift the TX register left by one on each synchronized sclk falling edge, except on a byte boundary.
REQ-019 SHALL treat a byte boundary as the first sclk falling edge after the counter wraps 7->0.
REQ-020 SHALL drive spi_miso = TX[7] while selected and 0 otherwise.
REQ-021 SHALL drive spi_miso_oe = synchronized cs_n inverted.
REQ-022 SHALL decode the RX byte at the CMD byte boundary: ==CMD_READ -> READ; ==CMD_STATUS -> STATUS; otherwise -> DISCARD.
REQ-023 SHALL, at each READ byte boundary (including the boundary that enters READ), load TX <= spi_data and assert spi_rd for exactly that one clk.
REQ-024 SHALL, at each STATUS byte boundary, load TX <= {6'b0, 1'b1, frame_ready}.
REQ-025 SHALL, at each DISCARD byte boundary, load TX <= 8'h00.
REQ-026 SHALL never pulse spi_rd in IDLE, CMD, STATUS or DISCARD.
REQ-027 SHALL pulse spi_rd at most once per 8 sclk periods.
REQ-028 SHALL, on a synchronized cs_n rising edge in any state, return to IDLE, discard any partial byte, and issue no spi_rd.
REQ-029 SHALL not restore a byte already consumed by spi_rd when cs_n rises mid-byte; that byte is lost, which is accepted behaviour.
REQ-030 SHALL ignore a cs_n rise and fall within the same clk; the synchronizer defines the transaction.
REQ-031 SHALL ignore sclk edges while cs_n is high.
REQ-032 SHALL give an upstream byte at least 8 sclk periods (>=64 clk) to settle after spi_rd before it is next sampled.

Reset
REQ-033 SHALL, while reset_n is low, hold state=IDLE, shift registers=0, bit counter=0, spi_rd=0, spi_miso=0, spi_miso_oe=0 and synchronizers at idle (cs_n=1, sclk=0).
REQ-034 SHALL, when reset asserts mid-transaction, abort immediately; after release it SHALL wait for a fresh cs_n falling edge.

Verification
REQ-035 SHALL cover STATUS: frame_ready=1, master sends 05 then 1 dummy byte -> MISO returns 00, 02+1=8'h03; no spi_rd pulses.
REQ-036 SHALL cover READ: upstream model presents FF,D8,FF,E0 advancing on spi_rd; master sends 03 + 4 dummy bytes -> MISO returns 00,FF,D8,FF,E0; exactly 4 spi_rd pulses, each 1 clk wide.
REQ-037 SHALL cover unknown opcode: master sends 9F + 2 bytes -> MISO returns 00,00,00; no spi_rd.
REQ-038 SHALL cover abort: cs_n rises after bit 3 of the 2nd READ data byte -> state IDLE within 3 clk, spi_miso_oe=0, total spi_rd pulses=2, next transaction starts clean.
REQ-039 SHALL cover clock ratio: clk = 8x sclk, 1024-byte READ against a counter source -> received bytes match sequence 00..FF repeating; spi_rd count = 1024.
REQ-040 SHALL cover reset: reset_n pulsed low during READ byte 5 -> outputs at reset values; subsequent STATUS transaction correct.

Source files
------------

// File: rtl/spi_slave_tx_if.sv
// spi_slave_tx_if -- bundle of the SPI pad signals and the upstream byte
// handshake used by spi_slave_tx.
//   spi_sclk, spi_cs_n, spi_mosi : from the SPI master (async to clk)
//   spi_miso, spi_miso_oe        : to the MISO pad
//   frame_ready                  : JPEG frame available (level)
//   spi_data, spi_rd             : upstream byte and its one-clk consume pulse
// Modport "slave" is the spi_slave_tx view; "master" is the driving side
// (SPI master plus upstream byte source).
interface spi_slave_tx_if;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       frame_ready;
  logic [7:0] spi_data;
  logic       spi_rd;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, frame_ready, spi_data,
    output spi_miso, spi_miso_oe, spi_rd
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, frame_ready, spi_data,
    input  spi_miso, spi_miso_oe, spi_rd
  );
endinterface

// File: rtl/spi_slave_tx.sv
// spi_slave_tx -- SPI mode-0 slave that streams JPEG bytes (CMD_READ) or a
// status byte (CMD_STATUS) back to the master. The SPI pins are
// oversampled on clk (clk >= 8x sclk).
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : spi_slave_tx_if.slave (SPI pins, frame_ready, spi_data/spi_rd)
module spi_slave_tx #(
  parameter logic [7:0] CMD_READ   = 8'h03,
  parameter logic [7:0] CMD_STATUS = 8'h05
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_slave_tx_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CMD, READ, STATUS, DISCARD} state_t;

  state_t     r_state;
  state_t     w_next;

  // [0] first sync flop, [1] synchronized value, [2] previous value
  logic [2:0] r_sclk_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx;
  logic [7:0] r_tx;
  logic       r_wrap;      // counter wrapped 7->0, next sclk fall is a byte boundary

  logic       w_sel;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_active;
  logic       w_boundary;
  logic       w_rd;
  logic [7:0] w_tx_load;
  logic [7:0] w_status;

  // Synchronizers; reset values match an idle bus (cs_n high, sclk low).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], bus.spi_sclk};
      r_cs_sync   <= {r_cs_sync[1:0],   bus.spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[0],   bus.spi_mosi};
    end
  end

  assign w_sel       = ~r_cs_sync[1];
  assign w_cs_fall   = ~r_cs_sync[1] &  r_cs_sync[2];
  assign w_cs_rise   =  r_cs_sync[1] & ~r_cs_sync[2];
  // sclk edges only count while selected
  assign w_sclk_rise = w_sel &  r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = w_sel & ~r_sclk_sync[1] &  r_sclk_sync[2];
  assign w_active    = w_sel & (r_state != IDLE);
  // w_sel excludes a same-cycle cs_n rise, so a boundary never coincides with an abort
  assign w_boundary  = w_active & w_sclk_fall & r_wrap;
  assign w_status    = {6'b0, 1'b1, bus.frame_ready};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_cs_fall) w_next = CMD;
        CMD: begin
          if (w_boundary) begin
            if (r_rx == CMD_READ)        w_next = READ;
            else if (r_rx == CMD_STATUS) w_next = STATUS;
            else                         w_next = DISCARD;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  // Output logic: byte to load at the next boundary and the consume pulse
  always_comb begin
    w_rd      = 1'b0;
    w_tx_load = '0;
    case (r_state)
      CMD: begin
        if (r_rx == CMD_READ) begin
          w_tx_load = bus.spi_data;
          w_rd      = w_boundary;
        end else if (r_rx == CMD_STATUS) begin
          w_tx_load = w_status;
        end
      end
      READ: begin
        w_tx_load = bus.spi_data;
        w_rd      = w_boundary;
      end
      STATUS:  w_tx_load = w_status;
      default: w_tx_load = '0;
    endcase
  end

  // Shift registers and bit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_wrap    <= 1'b0;
    end else if (w_cs_fall) begin
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_wrap    <= 1'b0;
    end else if (w_cs_rise) begin
      r_bit_cnt <= '0;
      r_wrap    <= 1'b0;
    end else if (w_active) begin
      if (w_sclk_rise) begin
        r_rx      <= {r_rx[6:0], r_mosi_sync[1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_wrap <= 1'b1;
      end else if (w_sclk_fall) begin
        if (r_wrap) begin
          r_wrap <= 1'b0;
          r_tx   <= w_tx_load;
        end else begin
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign bus.spi_miso    = w_sel & r_tx[7];
  assign bus.spi_miso_oe = w_sel;
  assign bus.spi_rd      = w_rd;

endmodule
